code_sequencer: RTL and testbench
=================================

Name: code_sequencer

Overview:
- Transmit end of the 3-button code interface: plays a programmed sequence of button symbols onto b[3:1] toward the lock FSM, then samples the FSM's outp and reports pass/fail.
- Sits between test/control logic (start, code) and the button-input FSM (b, outp).
- Allows directed, cycle-accurate exercise of the FSM in simulation and on the board.

Parameters:
- SEQ_LEN, 4, number of symbols per sequence (1..8).
- HOLD_CYC, 24, clk cycles each symbol is driven on b.
- GAP_CYC, 4, clk cycles of b=3'b000 after each symbol (0 allowed = no gap).
- TIMEOUT_CYC, 16, max cycles to wait for outp=1 after the last symbol.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  begin sequence; sampled only in IDLE.
- code  in  3*SEQ_LEN  symbols, symbol 0 in bits [2:0], symbol k in bits [3k+2:3k].
- outp  in  1  response from the FSM.
- b  out  3  button drive, declared [3:1]; b[1] = symbol bit 0.
- busy  out  1  high from the cycle after start accept until done.
- done  out  1  one-cycle pulse at end of sequence.
- pass  out  1  result; valid from the done cycle, held until the next start accept.
- early  out  1  outp seen high before the last symbol finished; held like pass.

Behaviour:
- Reset (async assert, sync release): state=IDLE; b=0, busy=0, done=0, pass=0, early=0; counters=0.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - start=1 latches code into a shadow register; clears pass and early.
  - Sets idx=0 and cnt=0, goes to DRIVE.
  - b becomes symbol 0 on the cycle after start is sampled (latency 1).
- DRIVE:
  - b = shadow[idx] for exactly HOLD_CYC cycles.
  - Then goes to GAP, or directly to NEXT when GAP_CYC=0.
- GAP: b=0 for exactly GAP_CYC cycles.
- NEXT (internal, no extra cycle):
  - If idx<SEQ_LEN-1: idx++ and return to DRIVE.
  - Otherwise go to WAIT with cnt=0.
- WAIT:
  - b=0 throughout.
  - If outp=1 on any of the first TIMEOUT_CYC cycles: pass=1, go to DONE.
  - If cnt reaches TIMEOUT_CYC: pass=0, go to DONE.
- DONE:
  - done=1 for one cycle; busy=0 in the same cycle; return to IDLE.
- early:
  - Set if outp=1 on any cycle in DRIVE or GAP before the last symbol's final cycle.
  - Sticky for the rest of the run.
- start while busy: ignored, with no effect on code or counters.
- start in the DONE cycle: ignored. start must be re-asserted in IDLE.
- Symbol 3'b000 in code is legal: drives no buttons for HOLD_CYC.
- Counters:
  - Width is clog2 of max(HOLD_CYC, GAP_CYC, TIMEOUT_CYC) + 1.
  - No wrap: each counter resets on every state entry.
- Total sequence length is SEQ_LEN*(HOLD_CYC+GAP_CYC) cycles of drive, plus at most TIMEOUT_CYC cycles of wait.
- rst mid-sequence: b goes to 0 immediately (async); no done pulse; pass/early cleared.
- code changes while busy have no effect; the shadow register is used.

Decomposition:
- Shared package:
  - State encoding constants: IDLE, DRIVE, GAP, WAIT, DONE.
  - Symbol width constant SYM_W=3.
  - Button symbol constants B1=3'b001, B2=3'b010, B3=3'b100.
- One natural sub-module, seq_timer: loadable down-counter with terminal-count pulse, reused for hold, gap and timeout.
- The FSM, index counter and shadow register stay in code_sequencer.

Test Plan:
- Reset with defaults (SEQ_LEN=4, HOLD_CYC=24, GAP_CYC=4) -> b=000, busy=0, done=0, pass=0 on every cycle until start.
- Start with code symbols {1,2,5,6}, outp tied 0 -> b sequence, each symbol 24 cycles followed by 4 cycles of 000:
  - b = 001, then 010, then 101, then 110.
  - done pulses exactly 112+16+1 cycles after start.
  - pass=0, early=0.
- Same code; a model FSM raises outp 3 cycles into WAIT -> done on the following cycle; pass=1, early=0.
- outp pulsed high during symbol 1 -> early=1 and held through done and after, until the next start clears it.
- start pulsed again at cycles 10 and 50 of a running sequence -> no change to b timing or symbols; exactly one done.
- rst asserted mid-symbol 2 (between clock edges) -> b=000 and busy=0 immediately; no done pulse; a new start runs from symbol 0.

Source files
------------

// File: rtl/code_sequencer_pkg.sv
// Shared types and constants for the button code sequencer.
// Latency: n/a; backpressure: n/a (declarations only).
package code_sequencer_pkg;

    localparam int SYM_W = 3;

    localparam logic [SYM_W-1:0] B1 = 3'b001;
    localparam logic [SYM_W-1:0] B2 = 3'b010;
    localparam logic [SYM_W-1:0] B3 = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/code_sequencer_timer.sv
// Loadable down-counter; tc is high while the count sits at zero (final cycle of a load).
// Latency: load takes effect on the next edge; backpressure: none.
module seq_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/code_sequencer.sv
// Plays a latched sequence of button symbols onto b, then waits for outp and reports pass/early.
// Latency: b shows symbol 0 one cycle after start is accepted; backpressure: start ignored while busy.
module code_sequencer
    import code_sequencer_pkg::*;
#(
    parameter int SEQ_LEN     = 4,
    parameter int HOLD_CYC    = 24,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SYM_W*SEQ_LEN-1:0] code,
    input  logic                     outp,
    output logic [3:1]               b,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     early
);

    localparam int CNT_W = $clog2(max3(HOLD_CYC, GAP_CYC, TIMEOUT_CYC)) + 1;
    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    // Timer is loaded with duration-1 so tc lands on the last cycle of each phase.
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    state_t                     state, state_n;
    logic [IDX_W-1:0]           idx, idx_n;
    logic [SYM_W*SEQ_LEN-1:0]   shadow, shadow_n;
    logic [3:1]                 b_n;
    logic                       busy_n, done_n, pass_n, early_n;
    logic                       tmr_load, tmr_tc, adv, last;
    logic [CNT_W-1:0]           tmr_val;

    assign last = (idx == LAST_IDX);

    seq_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            shadow <= '0;
            b      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
            early  <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            shadow <= shadow_n;
            b      <= b_n;
            busy   <= busy_n;
            done   <= done_n;
            pass   <= pass_n;
            early  <= early_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        shadow_n = shadow;
        b_n      = b;
        busy_n   = busy;
        done_n   = 1'b0;
        pass_n   = pass;
        early_n  = early;
        tmr_load = 1'b0;
        tmr_val  = '0;
        adv      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    shadow_n = code;
                    pass_n   = 1'b0;
                    early_n  = 1'b0;
                    idx_n    = '0;
                    b_n      = code[SYM_W-1:0];
                    busy_n   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    state_n  = DRIVE;
                end
            end
            DRIVE: begin
                // The final cycle of the last symbol is the first where a response is legitimate.
                if (outp && !(last && tmr_tc)) early_n = 1'b1;
                if (tmr_tc) begin
                    if (GAP_CYC > 0) begin
                        b_n      = '0;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                        state_n  = GAP;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: begin
                if (outp && !last) early_n = 1'b1;
                if (tmr_tc) adv = 1'b1;
            end
            WAIT: begin
                if (outp || tmr_tc) begin
                    pass_n  = outp;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Step to the next symbol, or into the response wait after the last one.
        if (adv) begin
            if (!last) begin
                idx_n    = idx + 1'b1;
                b_n      = shadow[int'(idx_n)*SYM_W +: SYM_W];
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
                state_n  = DRIVE;
            end else begin
                b_n      = '0;
                tmr_load = 1'b1;
                tmr_val  = TO_LD;
                state_n  = WAIT;
            end
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer with a cycle-position reference model.
module tb_code_sequencer;
    import code_sequencer_pkg::*;

    localparam int SEQ_LEN = 4;
    localparam int HOLD    = 24;
    localparam int GAPC    = 4;
    localparam int TO      = 16;
    localparam int PER     = HOLD + GAPC;
    localparam int DRV     = SEQ_LEN * PER;
    localparam int LAST_FINAL = (SEQ_LEN - 1) * PER + HOLD - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [SYM_W*SEQ_LEN-1:0] code;
    logic                     outp;
    logic [3:1]               b;
    logic                     busy, done, pass, early;

    always #5 clk = ~clk;

    code_sequencer #(
        .SEQ_LEN     (SEQ_LEN),
        .HOLD_CYC    (HOLD),
        .GAP_CYC     (GAPC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .code  (code),
        .outp  (outp),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .pass  (pass),
        .early (early)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: position t within the run decides the expected outputs.
    bit         m_run   = 1'b0;
    bit         m_done  = 1'b0;
    bit         m_pass  = 1'b0;
    bit         m_early = 1'b0;
    int         m_t     = 0;
    logic [2:0] m_sym [SEQ_LEN];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run   <= 1'b0;
            m_done  <= 1'b0;
            m_pass  <= 1'b0;
            m_early <= 1'b0;
            m_t     <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_run) begin
            if (m_t < DRV) begin
                if (outp && m_t < LAST_FINAL) m_early <= 1'b1;
                m_t <= m_t + 1;
            end else if (outp || (m_t - DRV) == TO - 1) begin
                m_pass <= outp;
                m_run  <= 1'b0;
                m_done <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (start) begin
            m_run   <= 1'b1;
            m_t     <= 0;
            m_pass  <= 1'b0;
            m_early <= 1'b0;
            for (int k = 0; k < SEQ_LEN; k++) m_sym[k] <= code[3*k +: 3];
        end
    end

    function automatic logic [2:0] exp_b();
        if (m_run && m_t < DRV && (m_t % PER) < HOLD) return m_sym[m_t / PER];
        return 3'b000;
    endfunction

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("b",     b,     exp_b());
            check("busy",  busy,  m_run);
            check("done",  done,  m_done);
            check("pass",  pass,  m_pass);
            check("early", early, m_early);
        end
    end

    logic [2:0] b_at [4];
    int         done_at;
    int         ndone;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle n=1 is the first cycle after the accepting edge; code is scrambled mid-run.
    task automatic run_seq(input logic [11:0] c, input int outp_n,
                           input int st1, input int st2, input int st3, input int ncyc);
        done_at = 0;
        ndone   = 0;
        code    = c;
        start   = 1'b1;
        cyc(1);
        for (int n = 1; n <= ncyc; n++) begin
            if (n == 1)  b_at[0] = b;
            if (n == 29) b_at[1] = b;
            if (n == 57) b_at[2] = b;
            if (n == 85) b_at[3] = b;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = n;
            end
            outp  = (n == outp_n);
            start = (n == st1) || (n == st2) || (n == st3);
            if (n == 5) code = ~c;
            cyc(1);
        end
        outp  = 1'b0;
        start = 1'b0;
    endtask

    logic [11:0] c1, c2;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        outp  = 1'b0;
        code  = '0;
        c1 = {B2 | B3, B1 | B3, B2, B1};
        c2 = {3'b000, B3, B1 | B2 | B3, B1 | B2};
        #2 rst = 1'b1;
        cyc(2);
        check("rst_b", b, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_early", early, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc(5);

        // Timeout run, no response
        run_seq(c1, 0, 0, 0, 0, 135);
        check("t1_sym0", b_at[0], 3'b001);
        check("t1_sym1", b_at[1], 3'b010);
        check("t1_sym2", b_at[2], 3'b101);
        check("t1_sym3", b_at[3], 3'b110);
        check("t1_done_at", done_at, 129);
        check("t1_ndone", ndone, 1);
        check("t1_pass", pass, 1'b0);
        check("t1_early", early, 1'b0);
        cyc(3);

        // Response three cycles into the wait window
        run_seq(c1, DRV + 4, 0, 0, 0, 125);
        check("t2_done_at", done_at, 117);
        check("t2_pass", pass, 1'b1);
        check("t2_early", early, 1'b0);
        cyc(3);

        // Response during symbol 1 is early and sticky
        run_seq(c1, 30, 0, 0, 0, 135);
        check("t3_done_at", done_at, 129);
        check("t3_pass", pass, 1'b0);
        check("t3_early_held", early, 1'b1);
        cyc(3);

        // Re-start while busy and in the done cycle is ignored
        run_seq(c1, 0, 10, 50, 129, 140);
        check("t4_ndone", ndone, 1);
        check("t4_done_at", done_at, 129);
        check("t4_early_clr", early, 1'b0);
        check("t4_no_restart", busy, 1'b0);
        check("t4_sym2", b_at[2], 3'b101);
        cyc(3);

        // Asynchronous reset in the middle of symbol 2
        code  = c1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(59);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_b", b, 3'b000);
        check("t5_rst_busy", busy, 1'b0);
        cyc(1);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 150; n++) begin
            if (done) ndone++;
            cyc(1);
        end
        check("t5_no_done", ndone, 0);

        // Fresh run after reset, including an all-zero symbol
        run_seq(c2, 0, 0, 0, 0, 135);
        check("t6_sym0", b_at[0], 3'b011);
        check("t6_sym1", b_at[1], 3'b111);
        check("t6_sym2", b_at[2], 3'b100);
        check("t6_sym3", b_at[3], 3'b000);
        check("t6_done_at", done_at, 129);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
